// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// multi-cycle execute waits with a timeout watchdog, and a saturating stall counter.
module pipe_stall_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReadE,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             Rs1UsedD,
    input  logic             Rs2UsedD,
    input  logic             PCSrcE,
    input  logic             McOpE,
    input  logic             McDoneE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             McGo,
    output logic             McErr,
    output logic [CNT_W-1:0] StallCnt,
    input  logic             CntClr,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ABORT = 2'b10
    } state_t;

    localparam int                TO_W    = $clog2(MC_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(MC_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              err_set;
    logic              lw_stall;

    assign lw_stall = MemReadE && (RD_E != 5'd0) &&
                      ((Rs1UsedD && (Rs1_D == RD_E)) || (Rs2UsedD && (Rs2_D == RD_E)));

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_set = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        McGo    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                // A taken branch discards D, so a pending load-use hazard is moot.
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (McOpE && !McDoneE) begin
                    McGo    = 1'b1;
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    state_d = ST_WAIT;
                    tmo_d   = TO_W'(1);
                end else if (McOpE) begin
                    state_d = ST_RUN;
                end else if (lw_stall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            ST_WAIT: begin
                if (McDoneE) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    if (tmo_q == TO_MAX) begin
                        state_d = ST_ABORT;
                        err_set = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TO_W'(1);
                    end
                end
            end
            ST_ABORT: begin
                // The hung op leaves E as a bubble while fetch/decode hold.
                StallF  = 1'b1;
                StallD  = 1'b1;
                FlushE  = 1'b1;
                state_d = ST_RUN;
                tmo_d   = '0;
            end
            default: begin
                state_d = ST_RUN;
                tmo_d   = '0;
            end
        endcase
        if (reset) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
            McGo   = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | err_set;
        if (CntClr) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (StallF && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            tmo_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign State    = state_q;
    assign StallCnt = cnt_q;
    assign McErr    = err_q;

    assert property (@(posedge clk) !(FlushD && StallD));
    assert property (@(posedge clk) StallE |-> (StallD && StallF));

endmodule
